// File: rtl/led_strip_tx_pkg.sv
// ---------------------------------------------------------------------------
// led_strip_tx_pkg
// Shared types and constants for the LED strip transmitter.
//   color_t        : 24-bit colour, [23:16]=R, [15:8]=G, [7:0]=B
//   R/G/B_MSB      : channel offsets inside a color_t
//   state_t, ST_*  : top-level FSM encoding (IDLE, PREP, SEND, LATCH)
//   to_grb()       : reorders an RGB colour into the on-wire GRB word
// ---------------------------------------------------------------------------
package led_strip_tx_pkg;

    typedef logic [23:0] color_t;

    localparam int R_MSB = 23;
    localparam int G_MSB = 15;
    localparam int B_MSB = 7;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PREP  = 2'd1;
    localparam state_t ST_SEND  = 2'd2;
    localparam state_t ST_LATCH = 2'd3;

    // The strip expects green first, then red, then blue, MSB first.
    function automatic color_t to_grb(input color_t c);
        return {c[G_MSB -: 8], c[R_MSB -: 8], c[B_MSB -: 8]};
    endfunction

endpackage

// File: rtl/led_strip_tx_if.sv
// ---------------------------------------------------------------------------
// led_strip_tx_if
// Frame request / status bundle between the visualizer and led_strip_tx.
//   rgb        : per-bin colour
//   LEDCounts  : per-bin LED count
//   start      : frame request
//   ledData    : serial line to the strip
//   busy       : frame in progress
//   done       : one-cycle end-of-frame pulse
//   dbg_state  : transmitter FSM state, for observation only
//
// Handshake: start is sampled on each rising clk edge while busy=0; the edge
// that sees start=1 accepts the frame, captures rgb/LEDCounts and raises busy
// from the next cycle on. start is ignored while busy=1. done pulses for one
// cycle with busy still high; busy drops on the following edge, and from that
// edge on a new start is accepted.
// ---------------------------------------------------------------------------
interface led_strip_tx_if #(
    parameter int LEDS    = 50,
    parameter int BIN_QTY = 12
);
    localparam int CW = $clog2(LEDS);

    logic [BIN_QTY-1:0][23:0]   rgb;
    logic [BIN_QTY-1:0][CW-1:0] LEDCounts;
    logic                       start;
    logic                       ledData;
    logic                       busy;
    logic                       done;
    logic [1:0]                 dbg_state;

    modport master (
        output rgb, LEDCounts, start,
        input  ledData, busy, done, dbg_state
    );

    modport slave (
        input  rgb, LEDCounts, start,
        output ledData, busy, done, dbg_state
    );
endinterface

// File: rtl/led_strip_tx_bit_encoder.sv
// ---------------------------------------------------------------------------
// ws2812_bit_encoder
// Serialises one 24-bit word, MSB first, as WS2812 pulses: each bit lasts
// TBIT cycles, high for T1H (bit=1) or T0H (bit=0) cycles, then low.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : accept i_word (honoured when idle or in the last cycle)
//   i_word       : word to send, bit 23 first
//   o_data       : serial output
//   o_word_done  : high during the final cycle of the current word
// ---------------------------------------------------------------------------
module ws2812_bit_encoder
    import led_strip_tx_pkg::*;
#(
    parameter int TBIT = 13,
    parameter int T0H  = 4,
    parameter int T1H  = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_load,
    input  color_t i_word,
    output logic   o_data,
    output logic   o_word_done
);
    localparam int CW = $clog2(TBIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] HIGH_0   = CW'(T0H);
    localparam logic [CW-1:0] HIGH_1   = CW'(T1H);

    color_t        r_shift;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_idx;
    logic          r_active;
    logic          w_bit_end;
    logic          w_last;

    assign w_bit_end   = r_active && (r_cnt == CNT_LAST);
    assign w_last      = w_bit_end && (r_idx == 5'd0);
    assign o_word_done = w_last;
    assign o_data      = r_active && (r_cnt < (r_shift[23] ? HIGH_1 : HIGH_0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_idx    <= 5'd0;
            r_active <= 1'b0;
        end else if (i_load && (!r_active || w_last)) begin
            // Reloading in the last cycle keeps consecutive words gap-free.
            r_shift  <= i_word;
            r_cnt    <= '0;
            r_idx    <= 5'd23;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_idx == 5'd0) begin
                    r_active <= 1'b0;
                end else begin
                    r_idx   <= r_idx - 5'd1;
                    r_shift <= {r_shift[22:0], 1'b0};
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/led_strip_tx.sv
// ---------------------------------------------------------------------------
// led_strip_tx
// Expands one visualizer frame (per-bin colour + per-bin LED count) into a
// LEDS-long pixel stream, sends it on a WS2812 one-wire line, then holds the
// line low for RESET_CYCLES before pulsing done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : led_strip_tx_if slave (rgb, LEDCounts, start in;
//              ledData, busy, done, dbg_state out)
// ---------------------------------------------------------------------------
module led_strip_tx
    import led_strip_tx_pkg::*;
#(
    parameter int LEDS         = 50,
    parameter int BIN_QTY      = 12,
    parameter int TBIT         = 13,
    parameter int T0H          = 4,
    parameter int T1H          = 8,
    parameter int RESET_CYCLES = 600
) (
    input  logic          clk,
    input  logic          rst,
    led_strip_tx_if.slave bus
);
    localparam int CW = $clog2(LEDS);
    localparam int BW = $clog2(BIN_QTY + 1);
    localparam int LW = $clog2(RESET_CYCLES);
    localparam logic [BW-1:0] BIN_END  = BW'(BIN_QTY);
    localparam logic [CW-1:0] LED_LAST = CW'(LEDS - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RESET_CYCLES - 1);

    // The background bin walk must finish within one pixel time.
    if (24 * TBIT <= BIN_QTY + 2) begin : g_bad_tbit
        $error("TBIT too small to walk all bins within one pixel");
    end
    if (!(T0H > 0 && T0H < T1H && T1H < TBIT)) begin : g_bad_timing
        $error("bit timing requires 0 < T0H < T1H < TBIT");
    end

    state_t                     r_state;
    logic [BIN_QTY-1:0][23:0]   r_rgb_sh;
    logic [BIN_QTY-1:0][CW-1:0] r_cnt_sh;
    logic [BW-1:0]              r_bin;    // bin feeding the next pixel
    logic [CW-1:0]              r_rem;    // pixels left in r_bin
    color_t                     r_color;  // next pixel, GRB order
    logic                       r_seek;   // background walk in progress
    logic                       r_load;   // first-pixel load strobe
    logic                       r_done;
    logic [CW-1:0]              r_led;
    logic [LW-1:0]              r_lat;

    color_t        w_sel_rgb;
    logic [CW-1:0] w_sel_cnt;
    logic          w_seeking;
    logic          w_load;
    logic          w_word_done;
    logic          w_data;

    // Selected bin; r_bin == BIN_END reads as black with zero count.
    always_comb begin
        w_sel_rgb = '0;
        w_sel_cnt = '0;
        for (int i = 0; i < BIN_QTY; i++) begin
            if (r_bin == BW'(i)) begin
                w_sel_rgb = r_rgb_sh[i];
                w_sel_cnt = r_cnt_sh[i];
            end
        end
    end

    assign w_seeking = (r_state == ST_PREP) || r_seek;
    assign w_load    = r_load || (w_word_done && (r_led != LED_LAST));

    ws2812_bit_encoder #(
        .TBIT (TBIT),
        .T0H  (T0H),
        .T1H  (T1H)
    ) u_enc (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_word      (r_color),
        .o_data      (w_data),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rgb_sh <= '0;
            r_cnt_sh <= '0;
            r_bin    <= '0;
            r_rem    <= '0;
            r_color  <= '0;
            r_seek   <= 1'b0;
            r_load   <= 1'b0;
            r_done   <= 1'b0;
            r_led    <= '0;
            r_lat    <= '0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_rgb_sh <= bus.rgb;
                        r_cnt_sh <= bus.LEDCounts;
                        r_bin    <= '0;
                        r_rem    <= '0;
                        r_color  <= '0;
                        r_seek   <= 1'b0;
                        r_led    <= '0;
                        r_lat    <= '0;
                        r_state  <= ST_PREP;
                    end
                end
                ST_PREP, ST_SEND: begin
                    if (w_load) begin
                        // The encoder just took r_color: consume one LED of
                        // the current bin, and start walking when it empties.
                        if (r_bin != BIN_END) begin
                            if (r_rem == CW'(1)) begin
                                r_bin  <= r_bin + BW'(1);
                                r_seek <= 1'b1;
                            end else begin
                                r_rem <= r_rem - CW'(1);
                            end
                        end
                    end else if (w_seeking) begin
                        if ((r_bin == BIN_END) || (w_sel_cnt != '0)) begin
                            r_color <= to_grb(w_sel_rgb);
                            r_rem   <= w_sel_cnt;
                            r_seek  <= 1'b0;
                            if (r_state == ST_PREP) begin
                                r_load  <= 1'b1;
                                r_state <= ST_SEND;
                            end
                        end else begin
                            r_bin <= r_bin + BW'(1);
                        end
                    end
                    if (w_word_done) begin
                        if (r_led == LED_LAST) begin
                            r_lat   <= '0;
                            r_state <= ST_LATCH;
                        end else begin
                            r_led <= r_led + CW'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (r_lat == LAT_LAST) begin
                        r_done <= 1'b1;
                    end else begin
                        r_lat <= r_lat + LW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ledData   = w_data;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_led_strip_tx.sv
// ---------------------------------------------------------------------------
// tb_led_strip_tx
// Self-checking bench for led_strip_tx with a small strip (4 LEDs, 2 bins).
// The expected line waveform is rebuilt from the frame contents: expand bins
// into pixels, pad/truncate to LEDS, reorder to GRB, turn every bit into a
// high/low pulse pattern, and frame it with the start latency and latch time.
// ---------------------------------------------------------------------------
module tb_led_strip_tx;
    import led_strip_tx_pkg::*;

    localparam int LEDS    = 4;
    localparam int BQ      = 2;
    localparam int TBIT    = 4;
    localparam int T0H     = 1;
    localparam int T1H     = 3;
    localparam int RST_CYC = 8;
    localparam int CW      = $clog2(LEDS);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_strip_tx_if #(.LEDS(LEDS), .BIN_QTY(BQ)) bus();

    led_strip_tx #(
        .LEDS         (LEDS),
        .BIN_QTY      (BQ),
        .TBIT         (TBIT),
        .T0H          (T0H),
        .T1H          (T1H),
        .RESET_CYCLES (RST_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [0:0]  exp_q[$];
    logic [23:0] m_rgb[BQ];
    int          m_cnt[BQ];

    // ---------------- reference model ----------------
    task automatic build_model();
        logic [23:0] pix[$];
        logic [23:0] p;
        logic [23:0] w;
        int z;
        int h;
        pix = {};
        for (int b = 0; b < BQ; b++)
            for (int n = 0; n < m_cnt[b]; n++)
                pix.push_back(m_rgb[b]);
        z = 0;
        for (int b = 0; b < BQ; b++) begin
            if (m_cnt[b] != 0) break;
            z++;
        end
        exp_q.delete();
        for (int i = 0; i < 2 + z; i++) exp_q.push_back(1'b0);
        for (int l = 0; l < LEDS; l++) begin
            p = (l < pix.size()) ? pix[l] : 24'h0;
            w = {p[15:8], p[23:16], p[7:0]};
            for (int bit_i = 23; bit_i >= 0; bit_i--) begin
                h = w[bit_i] ? T1H : T0H;
                for (int c = 0; c < TBIT; c++) exp_q.push_back((c < h) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 0; i < RST_CYC; i++) exp_q.push_back(1'b0);
    endtask

    task automatic set_frame(input logic [23:0] c0, input logic [23:0] c1,
                             input int n0, input int n1);
        m_rgb[0] = c0;
        m_rgb[1] = c1;
        m_cnt[0] = n0;
        m_cnt[1] = n1;
        build_model();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        logic [31:0] t;
        for (int b = 0; b < BQ; b++) begin
            t = m_cnt[b];
            bus.rgb[b]       = m_rgb[b];
            bus.LEDCounts[b] = t[CW-1:0];
        end
    endtask

    task automatic scramble_inputs();
        for (int b = 0; b < BQ; b++) begin
            bus.rgb[b]       = 24'($urandom());
            bus.LEDCounts[b] = CW'($urandom_range(0, LEDS - 1));
        end
    endtask

    // Leaves the bench 1 time unit after the accepting edge.
    task automatic start_frame();
        @(negedge clk);
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        scramble_inputs();
    endtask

    // Called just after the accepting edge; ends in the first idle cycle.
    task automatic check_frame(input string name);
        int n;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            checks++;
            if (bus.ledData !== exp_q[k]) begin
                errors++;
                $display("FAIL %s ledData cycle %0d got %b exp %b", name, k, bus.ledData, exp_q[k]);
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s status cycle %0d got busy=%b done=%b exp busy=1 done=0",
                         name, k, bus.busy, bus.done);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.ledData !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse cycle %0d got done=%b busy=%b ledData=%b exp 1 1 0",
                     name, n, bus.done, bus.busy, bus.ledData);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL %s end_idle got done=%b busy=%b state=%0d exp 0 0 %0d",
                     name, bus.done, bus.busy, bus.dbg_state, ST_IDLE);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        scramble_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ledData !== 1'b0) begin
            errors++;
            $display("FAIL reset_ledData got %b exp 0", bus.ledData);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b exp 0", bus.done);
        end
        checks++;
        if (bus.dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d exp %0d", bus.dbg_state, ST_IDLE);
        end
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        set_frame(24'hFF0000, 24'h0000FF, 2, 2);
        start_frame();
        check_frame("basic");
    endtask

    task automatic test_short_sum();
        set_frame(24'h123456, 24'($urandom()), 1, 0);
        start_frame();
        check_frame("short_sum");
    endtask

    task automatic test_leading_zero();
        set_frame(24'($urandom()), 24'h00FF00, 0, 3);
        start_frame();
        check_frame("leading_zero");
    endtask

    task automatic test_truncate();
        set_frame(24'($urandom()), 24'($urandom()), 3, 3);
        start_frame();
        check_frame("truncate");
    endtask

    task automatic test_all_zero();
        set_frame(24'($urandom()), 24'($urandom()), 0, 0);
        start_frame();
        check_frame("all_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            set_frame(24'($urandom()), 24'($urandom()),
                      $urandom_range(0, LEDS - 1), $urandom_range(0, LEDS - 1));
            start_frame();
            check_frame($sformatf("random%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        set_frame(24'($urandom()), 24'($urandom()),
                  $urandom_range(0, LEDS - 1), $urandom_range(0, LEDS - 1));
        @(negedge clk);
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        scramble_inputs();
        check_frame("held_a");
        // start stays high: the next edge must accept a new frame.
        set_frame(24'($urandom()), 24'($urandom()),
                  $urandom_range(0, LEDS - 1), $urandom_range(0, LEDS - 1));
        drive_inputs();
        @(posedge clk);
        #1;
        scramble_inputs();
        check_frame("held_b");
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL held_release busy cycle %0d got %b exp 0", i, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        set_frame(24'hFF0000, 24'h0000FF, 2, 2);
        start_frame();
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ledData !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got ledData=%b busy=%b done=%b exp 0 0 0",
                     bus.ledData, bus.busy, bus.done);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL reset_mid_quiet got activity after reset exp none");
        end
        start_frame();
        check_frame("after_reset");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        bus.start     = 1'b0;
        bus.rgb       = '0;
        bus.LEDCounts = '0;
        test_reset();
        test_basic();
        test_short_sum();
        test_leading_zero();
        test_truncate();
        test_all_zero();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
